alexcpt_ram_cfg: RTL and testbench
==================================

ALEXCPT_RAM_CFG -- requirements
Module: ALEXCPT_RAM_CFG

Interface
REQ-001 SHALL have parameters, one per line:
  RPORT  4  number of read ports (commit lanes), 1..8
  WPORT  2  number of write ports, 1..4
  DEPTH  128  entries; multiple of NUM_PARTS
  INDEX  7  address width, = clog2(DEPTH)
  WIDTH  8  entry width
  NUM_PARTS  4  power-gating partitions, power of 2, DEPTH/NUM_PARTS entries each
REQ-002 SHALL have ports, one per line:
  clk  in  1  clock
  reset  in  1  asynchronous, active-high reset
  addr_i  in  RPORT*INDEX  read addresses, lane r at [r*INDEX +: INDEX]
  data_o  out  RPORT*WIDTH  read data, lane r at [r*WIDTH +: WIDTH]
  readPortGated_i  in  RPORT  1 = lane r disabled
  wrAddr_i  in  WPORT*INDEX  write addresses
  wrData_i  in  WPORT*WIDTH  write data
  we_i  in  WPORT  write enables
  partitionGated_i  in  NUM_PARTS  1 = partition p powered off
  clear_i  in  1  synchronous request to re-zero the whole array
  ramReady_o  out  1  1 = array initialised, accepting writes
REQ-003 SHALL use a single clock domain, clk; reset is asynchronous and active-high.

Function
REQ-004 SHALL hold storage in a DEPTH x WIDTH array with no async reset on storage; zeroing is done only by the clear FSM.
REQ-005 SHALL read combinationally: data_o lane r = array[addr_i lane r], zero-latency.
REQ-006 SHALL drive lane r to 0 when readPortGated_i[r]=1, when addr >= DEPTH, when the addressed partition (addr / (DEPTH/NUM_PARTS)) is gated, or when ramReady_o=0.
REQ-007 SHALL return pre-write data on a read to an address written in the same cycle (no bypass); new data visible the cycle after the edge.
REQ-008 SHALL commit write port w at posedge clk when we_i[w]=1, ramReady_o=1, addr < DEPTH, and addressed partition not gated; otherwise the write is dropped silently.
REQ-009 SHALL resolve same-address writes in one cycle by highest port index winning; distinct addresses all commit.
REQ-010 SHALL implement FSM states CLEAR and READY with a clear counter clrIdx of INDEX bits.
REQ-011 CLEAR: each cycle write 0 to array[clrIdx], clrIdx+1; at clrIdx = DEPTH-1 write it and go to READY next cycle; ramReady_o=0 throughout; all user writes dropped.
REQ-012 READY: ramReady_o=1; clear_i=1 -> CLEAR, clrIdx=0, next cycle; user writes in that same cycle still commit.
REQ-013 SHALL take exactly DEPTH cycles in CLEAR, ramReady_o rising on cycle DEPTH after entry.
REQ-014 SHALL ignore clear_i while in CLEAR (no restart, no extension).
REQ-015 SHALL clear gated partitions too, so re-enabling a partition never exposes stale data.
REQ-016 SHALL not count past DEPTH-1 (no wrap to 0) for non-power-of-2 DEPTH.

Reset
REQ-017 SHALL on reset assertion, asynchronously: state=CLEAR, clrIdx=0, ramReady_o=0, data_o all 0.
REQ-018 SHALL on reset mid-CLEAR or mid-READY abandon progress and restart full clear from index 0 after deassertion.
REQ-019 SHALL begin clearing on the first posedge clk after reset deassertion.

Verification
REQ-020 Reset 1 cycle, deassert -> ramReady_o=0 for exactly 128 cycles, then 1; every lane reads 0x00 at all 128 addresses.
REQ-021 READY, port0 writes 0x5A@3 and port1 writes 0xA5@3 same cycle -> next cycle addr 3 reads 0xA5; same-cycle read of addr 3 returns 0x00.
REQ-022 readPortGated_i=4'b0010 with all lanes addr 3 (holding 0xA5) -> lanes 0,2,3 read 0xA5, lane 1 reads 0x00.
REQ-023 partitionGated_i=4'b0001, write 0x11@5 and 0x22@40 -> addr 40 reads 0x22; addr 5 reads 0; after ungating addr 5 reads 0x00 (write dropped).
REQ-024 Write 0x77@10, pulse clear_i, assert clear_i again at cycle 50 of CLEAR, write during CLEAR -> ramReady_o low exactly 128 cycles, addr 10 reads 0x00, CLEAR-cycle write absent.
REQ-025 Assert reset at CLEAR cycle 60 -> ramReady_o stays 0, full 128-cycle clear repeats after deassertion.

Source files
------------

// File: rtl/alexcpt_ram_cfg.sv
// Multi-port RAM with power-gated partitions and a sequential clear FSM
// that zeroes every entry after reset or on request before accepting writes.
module alexcpt_ram_cfg #(
    parameter int RPORT     = 4,
    parameter int WPORT     = 2,
    parameter int DEPTH     = 128,
    parameter int INDEX     = 7,
    parameter int WIDTH     = 8,
    parameter int NUM_PARTS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [RPORT*INDEX-1:0] addr_i,
    output logic [RPORT*WIDTH-1:0] data_o,
    input  logic [RPORT-1:0]       readPortGated_i,
    input  logic [WPORT*INDEX-1:0] wrAddr_i,
    input  logic [WPORT*WIDTH-1:0] wrData_i,
    input  logic [WPORT-1:0]       we_i,
    input  logic [NUM_PARTS-1:0]   partitionGated_i,
    input  logic                   clear_i,
    output logic                   ramReady_o
);

    localparam int PART_SIZE = DEPTH / NUM_PARTS;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t           state;
    logic [INDEX-1:0] clrIdx;
    logic [WIDTH-1:0] mem [DEPTH];

    // An address is live when it lies inside the array and its partition is powered.
    function automatic logic addr_live(input logic [INDEX-1:0] a,
                                       input logic [NUM_PARTS-1:0] gated);
        logic live;
        live = (int'(a) < DEPTH);
        for (int p = 0; p < NUM_PARTS; p++) begin
            if (gated[p] && int'(a) >= p * PART_SIZE && int'(a) < (p + 1) * PART_SIZE)
                live = 1'b0;
        end
        return live;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CLEAR;
            clrIdx     <= '0;
            ramReady_o <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clrIdx == INDEX'(DEPTH - 1)) begin
                        state      <= READY;
                        ramReady_o <= 1'b1;
                    end else begin
                        clrIdx <= clrIdx + INDEX'(1);
                    end
                end
                READY: begin
                    if (clear_i) begin
                        state      <= CLEAR;
                        clrIdx     <= '0;
                        ramReady_o <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Storage has no reset; later write ports overwrite earlier ones on a collision.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clrIdx] <= '0;
        end else begin
            for (int w = 0; w < WPORT; w++) begin
                if (we_i[w] && addr_live(wrAddr_i[w*INDEX +: INDEX], partitionGated_i))
                    mem[wrAddr_i[w*INDEX +: INDEX]] <= wrData_i[w*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        data_o = '0;
        for (int r = 0; r < RPORT; r++) begin
            if (ramReady_o && !readPortGated_i[r] &&
                addr_live(addr_i[r*INDEX +: INDEX], partitionGated_i))
                data_o[r*WIDTH +: WIDTH] = mem[addr_i[r*INDEX +: INDEX]];
        end
    end

endmodule

// File: tb/tb_alexcpt_ram_cfg.sv
// Self-checking bench for alexcpt_ram_cfg: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_alexcpt_ram_cfg;

    localparam int RPORT     = 4;
    localparam int WPORT     = 2;
    localparam int DEPTH     = 128;
    localparam int INDEX     = 7;
    localparam int WIDTH     = 8;
    localparam int NUM_PARTS = 4;
    localparam int PART      = DEPTH / NUM_PARTS;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [RPORT*INDEX-1:0] addr_i;
    logic [RPORT*WIDTH-1:0] data_o;
    logic [RPORT-1:0]       readPortGated_i;
    logic [WPORT*INDEX-1:0] wrAddr_i;
    logic [WPORT*WIDTH-1:0] wrData_i;
    logic [WPORT-1:0]       we_i;
    logic [NUM_PARTS-1:0]   partitionGated_i;
    logic                   clear_i;
    logic                   ramReady_o;

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] model_mem [DEPTH];
    bit               model_ready;
    int               model_left;

    always #5 clk = ~clk;

    alexcpt_ram_cfg #(
        .RPORT(RPORT), .WPORT(WPORT), .DEPTH(DEPTH),
        .INDEX(INDEX), .WIDTH(WIDTH), .NUM_PARTS(NUM_PARTS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .addr_i(addr_i),
        .data_o(data_o),
        .readPortGated_i(readPortGated_i),
        .wrAddr_i(wrAddr_i),
        .wrData_i(wrData_i),
        .we_i(we_i),
        .partitionGated_i(partitionGated_i),
        .clear_i(clear_i),
        .ramReady_o(ramReady_o)
    );

    function automatic logic [1:0] part_of(input logic [INDEX-1:0] a);
        return 2'(int'(a) / PART);
    endfunction

    function automatic logic [WIDTH-1:0] exp_lane(input int r);
        logic [INDEX-1:0] a;
        a = addr_i[r*INDEX +: INDEX];
        if (!model_ready || readPortGated_i[r] || partitionGated_i[part_of(a)])
            return '0;
        return model_mem[a];
    endfunction

    task automatic model_reset();
        model_ready = 1'b0;
        model_left  = DEPTH;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    // Reference behaviour of one clock edge given the currently driven inputs.
    task automatic model_edge();
        logic [INDEX-1:0] a;
        if (model_ready) begin
            for (int w = 0; w < WPORT; w++) begin
                a = wrAddr_i[w*INDEX +: INDEX];
                if (we_i[w] && !partitionGated_i[part_of(a)])
                    model_mem[a] = wrData_i[w*WIDTH +: WIDTH];
            end
            if (clear_i) begin
                model_ready = 1'b0;
                model_left  = DEPTH;
                for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
            end
        end else begin
            model_left--;
            if (model_left == 0) model_ready = 1'b1;
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_i             = '0;
        wrAddr_i         = '0;
        wrData_i         = '0;
        readPortGated_i  = '0;
        partitionGated_i = '0;
        clear_i          = 1'b0;
    endtask

    task automatic set_lanes(input logic [INDEX-1:0] a);
        for (int r = 0; r < RPORT; r++) addr_i[r*INDEX +: INDEX] = a;
    endtask

    task automatic test_reset();
        idle();
        set_lanes('0);
        reset = 1'b1;
        model_reset();
        #2;
        vectors++;
        if (ramReady_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b expected 0", ramReady_o);
        end
        vectors++;
        if (data_o !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %h expected 0", data_o);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (ramReady_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL init_ready_low cycle %0d: got %b expected 0", i, ramReady_o);
            end
            cycle();
        end
        vectors++;
        if (ramReady_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL init_ready_high: got %b expected 1", ramReady_o);
        end
        for (int a = 0; a < DEPTH; a++) begin
            set_lanes(INDEX'(a));
            #1;
            for (int r = 0; r < RPORT; r++) begin
                vectors++;
                if (data_o[r*WIDTH +: WIDTH] !== 8'h00) begin
                    miscompares++;
                    $display("[TB] FAIL init_zero addr %0d lane %0d: got %h expected 00",
                             a, r, data_o[r*WIDTH +: WIDTH]);
                end
            end
            cycle();
        end
    endtask

    task automatic test_write_priority();
        idle();
        we_i     = 2'b11;
        wrAddr_i = {7'd3, 7'd3};
        wrData_i = {8'hA5, 8'h5A};
        set_lanes(7'd3);
        #1;
        vectors++;
        if (data_o[0 +: WIDTH] !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL same_cycle_read: got %h expected 00", data_o[0 +: WIDTH]);
        end
        cycle();
        we_i = '0;
        #1;
        for (int r = 0; r < RPORT; r++) begin
            vectors++;
            if (data_o[r*WIDTH +: WIDTH] !== 8'hA5) begin
                miscompares++;
                $display("[TB] FAIL write_priority lane %0d: got %h expected a5",
                         r, data_o[r*WIDTH +: WIDTH]);
            end
        end
    endtask

    task automatic test_read_gating();
        logic [WIDTH-1:0] want;
        readPortGated_i = 4'b0010;
        set_lanes(7'd3);
        #1;
        for (int r = 0; r < RPORT; r++) begin
            want = (r == 1) ? 8'h00 : 8'hA5;
            vectors++;
            if (data_o[r*WIDTH +: WIDTH] !== want) begin
                miscompares++;
                $display("[TB] FAIL read_gating lane %0d: got %h expected %h",
                         r, data_o[r*WIDTH +: WIDTH], want);
            end
        end
        readPortGated_i = '0;
        cycle();
    endtask

    task automatic test_partition_gating();
        idle();
        partitionGated_i = 4'b0001;
        we_i     = 2'b11;
        wrAddr_i = {7'd40, 7'd5};
        wrData_i = {8'h22, 8'h11};
        cycle();
        we_i = '0;
        addr_i[0*INDEX +: INDEX] = 7'd40;
        addr_i[1*INDEX +: INDEX] = 7'd5;
        #1;
        vectors++;
        if (data_o[0 +: WIDTH] !== 8'h22) begin
            miscompares++;
            $display("[TB] FAIL part_ungated_read: got %h expected 22", data_o[0 +: WIDTH]);
        end
        vectors++;
        if (data_o[WIDTH +: WIDTH] !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL part_gated_read: got %h expected 00", data_o[WIDTH +: WIDTH]);
        end
        partitionGated_i = '0;
        #1;
        vectors++;
        if (data_o[WIDTH +: WIDTH] !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL part_write_dropped: got %h expected 00", data_o[WIDTH +: WIDTH]);
        end
        cycle();
    endtask

    task automatic test_clear();
        idle();
        we_i     = 2'b01;
        wrAddr_i = {7'd0, 7'd10};
        wrData_i = {8'h00, 8'h77};
        cycle();
        we_i = '0;
        set_lanes(7'd10);
        #1;
        vectors++;
        if (data_o[0 +: WIDTH] !== 8'h77) begin
            miscompares++;
            $display("[TB] FAIL pre_clear_write: got %h expected 77", data_o[0 +: WIDTH]);
        end
        clear_i = 1'b1;
        cycle();
        clear_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 50) clear_i = 1'b1;
            if (i == 60) begin
                we_i     = 2'b01;
                wrAddr_i = {7'd0, 7'd20};
                wrData_i = {8'h00, 8'h33};
            end
            #1;
            vectors++;
            if (ramReady_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL clear_ready_low cycle %0d: got %b expected 0", i, ramReady_o);
            end
            cycle();
            clear_i = 1'b0;
            we_i    = '0;
        end
        vectors++;
        if (ramReady_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL clear_ready_high: got %b expected 1", ramReady_o);
        end
        addr_i[0*INDEX +: INDEX] = 7'd10;
        addr_i[1*INDEX +: INDEX] = 7'd20;
        #1;
        vectors++;
        if (data_o[0 +: WIDTH] !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL clear_zeroed: got %h expected 00", data_o[0 +: WIDTH]);
        end
        vectors++;
        if (data_o[WIDTH +: WIDTH] !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL clear_write_dropped: got %h expected 00", data_o[WIDTH +: WIDTH]);
        end
        cycle();
        vectors++;
        if (ramReady_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL clear_no_restart: got %b expected 1", ramReady_o);
        end
    endtask

    task automatic test_reset_mid_clear();
        idle();
        clear_i = 1'b1;
        cycle();
        clear_i = 1'b0;
        for (int i = 0; i < 60; i++) cycle();
        reset = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (ramReady_o !== 1'b0 || data_o !== '0) begin
            miscompares++;
            $display("[TB] FAIL mid_clear_reset: got ready %b data %h expected 0/0",
                     ramReady_o, data_o);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (ramReady_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reclear_ready_low cycle %0d: got %b expected 0", i, ramReady_o);
            end
            cycle();
        end
        vectors++;
        if (ramReady_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reclear_ready_high: got %b expected 1", ramReady_o);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] want;
        for (int n = 0; n < 600; n++) begin
            we_i = 2'($urandom_range(0, 3));
            for (int w = 0; w < WPORT; w++) begin
                wrAddr_i[w*INDEX +: INDEX] = ($urandom_range(0, 1) == 1) ?
                    INDEX'($urandom_range(0, 15)) : INDEX'($urandom_range(0, DEPTH - 1));
                wrData_i[w*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 3) == 0) wrAddr_i[INDEX +: INDEX] = wrAddr_i[0 +: INDEX];
            for (int r = 0; r < RPORT; r++) begin
                addr_i[r*INDEX +: INDEX] = ($urandom_range(0, 1) == 1) ?
                    INDEX'($urandom_range(0, 15)) : INDEX'($urandom_range(0, DEPTH - 1));
            end
            readPortGated_i  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : '0;
            partitionGated_i = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : '0;
            clear_i          = ($urandom_range(0, 199) == 0);
            #1;
            vectors++;
            if (ramReady_o !== model_ready) begin
                miscompares++;
                $display("[TB] FAIL rand_ready iter %0d: got %b expected %b",
                         n, ramReady_o, model_ready);
            end
            for (int r = 0; r < RPORT; r++) begin
                want = exp_lane(r);
                vectors++;
                if (data_o[r*WIDTH +: WIDTH] !== want) begin
                    miscompares++;
                    $display("[TB] FAIL rand_read iter %0d lane %0d addr %0d: got %h expected %h",
                             n, r, addr_i[r*INDEX +: INDEX], data_o[r*WIDTH +: WIDTH], want);
                end
            end
            cycle();
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        addr_i = '0;
        test_reset();
        test_write_priority();
        test_read_gating();
        test_partition_gating();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
